// File: rtl/dense_argmax.sv
// -----------------------------------------------------------------------------
// dense_argmax
//   Classifier stage behind the final dense layer. It accepts one neuron score
//   per valid_i strobe, neurons 0..BIAS-1 in order. Each score can optionally
//   be passed through ReLU. Every score is written into a readable buffer, and
//   the block tracks the running maximum. When a frame completes, the block
//   pulses valid_o for one cycle with the winning index and value.
//
//   Handshake: valid_i is a one-way strobe with no ready. The block accepts a
//   score on every cycle that valid_i is high, and gaps of any length are
//   allowed. valid_o is a one-cycle pulse with no backpressure. class_o and
//   score_o hold their values until the next completed frame.
//
// Ports
//   clk        clock
//   rstn       synchronous reset, active-low
//   valid_i    data_i carries the next neuron score this cycle
//   data_i     score, sign-magnitude float (MSB sign, rest magnitude)
//   busy_o     frame in progress (FSM in ACCUM); doubles as FSM state view
//   valid_o    one-cycle pulse: class_o/score_o updated
//   class_o    index of the maximum score of the last completed frame
//   score_o    maximum (post-ReLU) score of the last completed frame
//   rd_addr_i  score buffer read address
//   rd_data_o  score buffer read data, registered, 1-cycle latency
// -----------------------------------------------------------------------------
module dense_argmax #(
  parameter int BIAS       = 128,
  parameter int DATA_WIDTH = 8,
  parameter int RELU       = 0,
  // Bits needed to hold BIAS-1 (equals ceil(log2(BIAS)) for BIAS >= 2).
  localparam int IDXW      = $clog2(BIAS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [IDXW-1:0]       class_o,
  output logic [DATA_WIDTH-1:0] score_o,
  input  logic [IDXW-1:0]       rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam logic [IDXW-1:0] LAST   = IDXW'(BIAS - 1);
  localparam logic [IDXW-1:0] ONE    = IDXW'(1);
  localparam logic [IDXW:0]   BIAS_W = (IDXW + 1)'(BIAS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDXW-1:0]       r_cnt;
  logic [IDXW-1:0]       w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_run_max;
  logic [DATA_WIDTH-1:0] w_run_max_nxt;
  logic [IDXW-1:0]       r_run_idx;
  logic [IDXW-1:0]       w_run_idx_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic [IDXW-1:0]       r_class;
  logic [IDXW-1:0]       w_class_nxt;
  logic [DATA_WIDTH-1:0] r_score;
  logic [DATA_WIDTH-1:0] w_score_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_buf [BIAS];

  logic [DATA_WIDTH-1:0] w_score_in;
  logic                  w_beats;
  logic                  w_we;
  logic [IDXW-1:0]       w_waddr;

  // Strict "a greater than b" for sign-magnitude values. +0 and -0 compare
  // equal. All-ones exponents are treated as ordinary magnitudes.
  function automatic logic beats(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
      2'b00:   return ma > mb;
      2'b01:   return (ma != '0) || (mb != '0);
      2'b10:   return 1'b0;
      default: return ma < mb;
    endcase
  endfunction

  assign w_score_in = ((RELU != 0) && data_i[DATA_WIDTH-1]) ? '0 : data_i;
  assign w_beats    = beats(w_score_in, r_run_max);

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_run_max_nxt = r_run_max;
    w_run_idx_nxt = r_run_idx;
    w_valid_nxt   = 1'b0;
    w_class_nxt   = r_class;
    w_score_nxt   = r_score;
    w_we          = 1'b0;
    w_waddr       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_we          = 1'b1;
          w_waddr       = '0;
          w_run_max_nxt = w_score_in;
          w_run_idx_nxt = '0;
          w_cnt_nxt     = ONE;
          w_state_nxt   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (valid_i) begin
          w_we    = 1'b1;
          w_waddr = r_cnt;
          // Replace only on strictly greater, so ties keep the earlier index.
          if (w_beats) begin
            w_run_max_nxt = w_score_in;
            w_run_idx_nxt = r_cnt;
          end
          if (r_cnt == LAST) begin
            w_valid_nxt = 1'b1;
            w_class_nxt = w_beats ? r_cnt : r_run_idx;
            w_score_nxt = w_beats ? w_score_in : r_run_max;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_valid   <= 1'b0;
      r_class   <= '0;
      r_score   <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_run_max <= w_run_max_nxt;
      r_run_idx <= w_run_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_class   <= w_class_nxt;
      r_score   <= w_score_nxt;
    end
  end

  // Score buffer contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= w_score_in;
  end

  // Read before write: a same-cycle write to rd_addr_i returns the old word.
  always_ff @(posedge clk) begin
    if (!rstn)                          r_rd_data <= '0;
    else if ({1'b0, rd_addr_i} < BIAS_W) r_rd_data <= r_buf[rd_addr_i];
    else                                r_rd_data <= '0;
  end

  assign busy_o    = (r_state == S_ACCUM);
  assign valid_o   = r_valid;
  assign class_o   = r_class;
  assign score_o   = r_score;
  assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_dense_argmax.sv
module tb_dense_argmax;
  localparam int BIAS = 10;
  localparam int W    = 8;
  localparam int IDXW = 4;
  localparam int RW   = IDXW + W;
  localparam int EW   = 32 + RW;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            valid_i   = 1'b0;
  logic [W-1:0]    data_i    = '0;
  logic [IDXW-1:0] rd_addr_i = '0;

  logic            busy0, valid0, busy1, valid1;
  logic [IDXW-1:0] class0, class1;
  logic [W-1:0]    score0, score1, rd0, rd1;

  dense_argmax #(.BIAS(BIAS), .DATA_WIDTH(W), .RELU(0)) dut0 (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i),
    .busy_o(busy0), .valid_o(valid0), .class_o(class0), .score_o(score0),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd0)
  );

  dense_argmax #(.BIAS(BIAS), .DATA_WIDTH(W), .RELU(1)) dut1 (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i),
    .busy_o(busy1), .valid_o(valid1), .class_o(class1), .score_o(score1),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd1)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  logic [W-1:0]  fr[$];
  logic [W-1:0]  mbuf0 [BIAS];
  logic [W-1:0]  mbuf1 [BIAS];
  logic [RW-1:0] last0 = '0;
  logic [RW-1:0] last1 = '0;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    return v[W-1] ? '0 : v;
  endfunction

  // Signed numeric value of a sign-magnitude word; -0 maps to 0.
  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? -int'(v[W-2:0]) : int'(v[W-2:0]);
  endfunction

  function automatic logic [RW-1:0] ref_argmax(input bit use_relu);
    int best;
    logic [W-1:0] x, xb;
    best = 0;
    xb = use_relu ? relu(fr[0]) : fr[0];
    for (int i = 1; i < fr.size(); i++) begin
      x = use_relu ? relu(fr[i]) : fr[i];
      if (sval(x) > sval(xb)) begin
        best = i;
        xb = x;
      end
    end
    return {IDXW'(best), xb};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rstn = 1'b0;
    step();
    chk("rst_busy0", busy0, 0);   chk("rst_busy1", busy1, 0);
    chk("rst_valid0", valid0, 0); chk("rst_valid1", valid1, 0);
    chk("rst_class0", class0, 0); chk("rst_class1", class1, 0);
    chk("rst_score0", score0, 0); chk("rst_score1", score1, 0);
    chk("rst_rd0", rd0, 0);       chk("rst_rd1", rd1, 0);
    rstn = 1'b1;
    fr.delete();
    last0 = '0;
    last1 = '0;
  endtask

  task automatic send(input logic [W-1:0] d, input int gap, input bit rd_same);
    int a;
    logic [W-1:0] old0, old1;
    a = fr.size();
    valid_i = 1'b1;
    data_i  = d;
    if (rd_same) rd_addr_i = IDXW'(a);
    old0 = mbuf0[a];
    old1 = mbuf1[a];
    step();
    valid_i = 1'b0;
    mbuf0[a] = d;
    mbuf1[a] = relu(d);
    fr.push_back(d);
    if (rd_same) begin
      chk("rd_old0", rd0, old0);
      chk("rd_old1", rd1, old1);
    end
    if (fr.size() == BIAS) begin
      exp0_q.push_back({cyc, ref_argmax(1'b0)});
      exp1_q.push_back({cyc, ref_argmax(1'b1)});
      fr.delete();
    end
    chk("busy0", busy0, fr.size() != 0);
    chk("busy1", busy1, fr.size() != 0);
    if (gap > 0) begin
      repeat (gap) step();
      chk("busy_gap0", busy0, fr.size() != 0);
      chk("busy_gap1", busy1, fr.size() != 0);
    end
  endtask

  task automatic rd_chk(input int a);
    rd_addr_i = IDXW'(a);
    step();
    chk("rd0", rd0, (a < BIAS) ? mbuf0[a] : '0);
    chk("rd1", rd1, (a < BIAS) ? mbuf1[a] : '0);
  endtask

  task automatic hold_chk();
    chk("hold0", {class0, score0}, last0);
    chk("hold1", {class1, score1}, last1);
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] e0, e1;
  initial begin
    forever begin
      @(negedge clk);
      if (valid0) begin
        chk("valid0_expected", exp0_q.size() != 0, 1);
        if (exp0_q.size() != 0) begin
          e0 = exp0_q.pop_front();
          chk("latency0", cyc, e0[EW-1 -: 32]);
          chk("class0", class0, e0[RW-1:W]);
          chk("score0", score0, e0[W-1:0]);
          last0 = e0[RW-1:0];
        end
      end
      if (valid1) begin
        chk("valid1_expected", exp1_q.size() != 0, 1);
        if (exp1_q.size() != 0) begin
          e1 = exp1_q.pop_front();
          chk("latency1", cyc, e1[EW-1 -: 32]);
          chk("class1", class1, e1[RW-1:W]);
          chk("score1", score1, e1[W-1:0]);
          last1 = e1[RW-1:0];
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] specials [6];
  logic [W-1:0] d;

  initial begin
    specials[0] = 8'h00; specials[1] = 8'h80; specials[2] = 8'h45;
    specials[3] = 8'hC5; specials[4] = 8'h7F; specials[5] = 8'hFF;

    repeat (3) step();
    do_reset();

    // Ascending scores, no gaps.
    for (int k = 0; k < BIAS; k++) send(W'(k), 0, 1'b0);
    repeat (2) step();
    hold_chk();

    // Tie at idx3 and idx7: earlier index wins.
    for (int k = 0; k < BIAS; k++) send((k == 3 || k == 7) ? 8'h45 : 8'h30, 0, 1'b0);
    repeat (2) step();

    // All negative: -0 is the largest; with ReLU everything is zero.
    for (int k = 0; k < BIAS; k++) send(8'h80 | W'(k), 0, 1'b0);
    repeat (2) step();
    for (int a = 0; a < 16; a++) rd_chk(a);

    // Sparse pacing, one score every 64 cycles.
    for (int k = 0; k < BIAS; k++) send((k == 5) ? 8'h7E : 8'h10 + W'(k), 63, 1'b0);
    repeat (2) step();
    hold_chk();

    // Two frames back to back, valid_i high for 20 cycles.
    for (int k = 0; k < 2 * BIAS; k++) send(W'($urandom_range(0, 255)), 0, 1'b0);
    repeat (2) step();

    // Read the address being written in the same cycle.
    for (int k = 0; k < BIAS; k++) send(W'($urandom_range(0, 255)), 0, 1'b1);
    repeat (2) step();

    // Reset mid-frame, then a full frame with the maximum at idx2.
    for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 255)), 0, 1'b0);
    do_reset();
    for (int k = 0; k < BIAS; k++) send((k == 2) ? 8'h70 : W'($urandom_range(0, 63)), 0, 1'b0);
    repeat (2) step();
    rd_chk(2);
    hold_chk();

    // Random frames with special values, random gaps, random reads.
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < BIAS; k++) begin
        if ($urandom_range(0, 2) == 0) d = specials[$urandom_range(0, 5)];
        else                           d = W'($urandom_range(0, 255));
        send(d, $urandom_range(0, 2), 1'b0);
      end
      repeat (2) step();
      hold_chk();
      rd_chk($urandom_range(0, 15));
    end

    repeat (3) step();
    chk("exp0_q_empty", exp0_q.size(), 0);
    chk("exp1_q_empty", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
